line_buffer_3row: RTL

- Upstream feeder for the 3x3 window register of the Conv2d path.
- Accepts a raster-order pixel stream (row-major, one pixel per handshake) and stores the two previous image rows in line memories.
- For every accepted pixel, presents the three vertically aligned pixels of the current column (rows r, r-1, r-2) to the window register, together with its Wr_window/Shift_window strobes.
- Flags when the window register holds a complete 3x3 window, so the downstream MAC can consume it.

---
 rtl/line_buffer_3row_if.sv | 29 ++
 rtl/line_buffer_3row.sv | 108 ++++++++++
 2 files changed

// File: rtl/line_buffer_3row_if.sv
// Pixel stream in, three-row column out: the handshake and window-register
// feed between line_buffer_3row and its neighbours.
interface line_buffer_3row_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_pixel;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_row_n;
  logic [DATA_WIDTH-1:0] out_row_n_1;
  logic [DATA_WIDTH-1:0] out_row_n_2;
  logic                  Wr_window;
  logic                  Shift_window;
  logic                  window_valid;
  logic                  frame_done;

  // Upstream source plus downstream window register, seen from outside the block.
  modport master (
    output in_valid, in_pixel,
    input  in_ready, out_row_n, out_row_n_1, out_row_n_2,
    input  Wr_window, Shift_window, window_valid, frame_done
  );

  modport slave (
    input  in_valid, in_pixel,
    output in_ready, out_row_n, out_row_n_1, out_row_n_2,
    output Wr_window, Shift_window, window_valid, frame_done
  );
endinterface

// File: rtl/line_buffer_3row.sv
// Two-line buffer feeding a 3x3 window register: for every accepted raster
// pixel it emits the column (r, r-1, r-2) and flags completed windows.
module line_buffer_3row #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int COL_W      = 6,
  parameter int ROW_W      = 6
) (
  input  logic               clk,
  input  logic               Rst_linebuf,
  line_buffer_3row_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN1,
    DRAIN2
  } state_t;

  state_t state_q, state_d;

  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      row_q;
  logic                  in_ready_q;
  logic [DATA_WIDTH-1:0] row_n_q, row_n_1_q, row_n_2_q;
  logic                  wr_q, shift_q;
  logic                  win_d1_q, window_valid_q, frame_done_q;

  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2 [IMG_WIDTH];

  logic accept;
  logic last_col, last_row;
  logic win_flag;

  assign accept   = bus.in_valid && in_ready_q;
  assign last_col = (col_q == COL_W'(IMG_WIDTH - 1));
  assign last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));
  // Columns 0 and 1 of a row still hold stale columns of the previous row.
  assign win_flag = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (accept && last_col && last_row) state_d = DRAIN1;
      DRAIN1:  state_d = DRAIN2;
      DRAIN2:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!Rst_linebuf) begin
      state_q        <= RUN;
      col_q          <= '0;
      row_q          <= '0;
      in_ready_q     <= 1'b0;
      row_n_q        <= '0;
      row_n_1_q      <= '0;
      row_n_2_q      <= '0;
      wr_q           <= 1'b0;
      shift_q        <= 1'b0;
      win_d1_q       <= 1'b0;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= (state_d == RUN);
      frame_done_q   <= (state_d == DRAIN2);
      wr_q           <= accept;
      shift_q        <= accept;
      win_d1_q       <= win_flag;
      window_valid_q <= win_d1_q;
      if (accept) begin
        row_n_q   <= bus.in_pixel;
        row_n_1_q <= (row_q == '0) ? '0 : lb1[col_q];
        row_n_2_q <= (row_q < ROW_W'(2)) ? '0 : lb2[col_q];
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // NOTE: line memories carry no reset; rows 0 and 1 mask their stale contents at the read side.
  always_ff @(posedge clk) begin
    if (Rst_linebuf && accept) begin
      lb2[col_q] <= lb1[col_q];
      lb1[col_q] <= bus.in_pixel;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_row_n    = row_n_q;
  assign bus.out_row_n_1  = row_n_1_q;
  assign bus.out_row_n_2  = row_n_2_q;
  assign bus.Wr_window    = wr_q;
  assign bus.Shift_window = shift_q;
  assign bus.window_valid = window_valid_q;
  assign bus.frame_done   = frame_done_q;

endmodule
